// File: rtl/serial_bus_pkg.sv
// Shared definitions for the bit-serial bus responder: FSM states, default widths
// and the rule that a burst count of zero still moves one word.
package serial_bus_pkg;

  localparam int DEF_ADDR_W  = 12;
  localparam int DEF_BURST_W = 13;
  localparam int DEF_DATA_W  = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HDR    = 3'd1,
    ST_WDATA  = 3'd2,
    ST_WMEM   = 3'd3,
    ST_RFETCH = 3'd4,
    ST_RSHIFT = 3'd5,
    ST_DONE   = 3'd6
  } state_t;

  function automatic logic [31:0] burst_words(input logic [31:0] burst);
    return (burst == 32'd0) ? 32'd1 : burst;
  endfunction

endpackage

// File: rtl/serial_slave_port_if.sv
// Serial lane between the master side (mux outputs) and the slave port.
interface serial_slave_port_if;

  logic read_en;
  logic write_en;
  logic master_valid;
  logic master_ready;
  logic rx_done_in;
  logic rx_address;
  logic rx_burst;
  logic rx_data;
  logic slave_ready;
  logic slave_valid;
  logic tx_data;
  logic slave_tx_done;
  logic parity_err;

  modport slave (
    input  read_en, write_en, master_valid, master_ready, rx_done_in,
           rx_address, rx_burst, rx_data,
    output slave_ready, slave_valid, tx_data, slave_tx_done, parity_err
  );

  modport master (
    output read_en, write_en, master_valid, master_ready, rx_done_in,
           rx_address, rx_burst, rx_data,
    input  slave_ready, slave_valid, tx_data, slave_tx_done, parity_err
  );

endinterface

// File: rtl/serial_shift_unit.sv
// Generic MSB-first bit shifter with parallel load, beat counter and a last-beat flag;
// exposes the top OUT_W bits so a serialiser can tap just the MSB.
module serial_shift_unit #(
  parameter int LEN   = 8,
  parameter int OUT_W = LEN
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             load,
  input  logic [LEN-1:0]   load_data,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [OUT_W-1:0] tap,
  output logic             last
);

  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  logic [LEN-1:0]   sr_reg;
  logic [CNT_W-1:0] cnt_reg;

  assign last = shift_en && (cnt_reg == LAST_CNT);
  assign tap  = sr_reg[LEN-1 -: OUT_W];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (clr) begin
      sr_reg  <= '0;
      cnt_reg <= '0;
    end else if (load) begin
      sr_reg  <= load_data;
      cnt_reg <= '0;
    end else if (shift_en) begin
      sr_reg  <= {sr_reg[LEN-2:0], bit_in};
      cnt_reg <= last ? '0 : cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/serial_slave_port.sv
// Bit-serial responder: decodes header, bursts words to/from a sync memory.
// Optional SERIAL_SLAVE_PARITY_EN adds a trailing even-parity beat per data word.
module serial_slave_port
  import serial_bus_pkg::*;
#(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int BURST_W = DEF_BURST_W,
  parameter int DATA_W  = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  serial_slave_port_if.slave bus,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int WORD_LEN = DATA_W + 1;
`else
  localparam int WORD_LEN = DATA_W;
`endif

  localparam int HDR_BEATS = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
  localparam int HC_W      = $clog2(HDR_BEATS + 1);
  localparam logic [HC_W-1:0] ADDR_BEATS  = HC_W'(ADDR_W);
  localparam logic [HC_W-1:0] BURST_BEATS = HC_W'(BURST_W);
  localparam logic [HC_W-1:0] HDR_LAST    = HC_W'(HDR_BEATS - 1);

  state_t              state_reg, state_next;
  logic                is_write_reg;
  logic                fetch_wait_reg;
  logic [HC_W-1:0]     hdr_cnt_reg;
  logic [ADDR_W-1:0]   addr_reg;
  logic [BURST_W-1:0]  burst_reg;
  logic [BURST_W-1:0]  k_reg;

  logic                start;
  logic                hdr_beat;
  logic                hdr_last;
  logic                more_words;
  logic                parity_ok;
  logic                rx_shift_en;
  logic                rx_last;
  logic [WORD_LEN-1:0] rx_word;
  logic [DATA_W-1:0]   rx_data_word;
  logic                tx_load;
  logic                tx_shift_en;
  logic                tx_last;
  logic [WORD_LEN-1:0] tx_load_data;
  logic [0:0]          tx_tap;

  assign start       = (state_reg == ST_IDLE) && (bus.read_en ^ bus.write_en);
  assign hdr_beat    = (state_reg == ST_HDR) && bus.master_valid;
  assign hdr_last    = hdr_beat && (hdr_cnt_reg == HDR_LAST);
  assign more_words  = (32'(k_reg) + 32'd1) < burst_words(32'(burst_reg));
  assign rx_shift_en = (state_reg == ST_WDATA) && bus.master_valid;
  assign tx_shift_en = (state_reg == ST_RSHIFT) && bus.master_ready;
  // mem_rdata is valid on the second RFETCH cycle, so the serialiser loads then
  assign tx_load     = (state_reg == ST_RFETCH) && fetch_wait_reg;
  assign rx_data_word = rx_word[WORD_LEN-1 -: DATA_W];

`ifdef SERIAL_SLAVE_PARITY_EN
  assign parity_ok    = ~^rx_word;
  assign tx_load_data = {mem_rdata, ^mem_rdata};
`else
  assign parity_ok    = 1'b1;
  assign tx_load_data = mem_rdata;
`endif

  serial_shift_unit #(.LEN(WORD_LEN), .OUT_W(WORD_LEN)) u_rx (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_reg == ST_IDLE),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (rx_shift_en),
    .bit_in    (bus.rx_data),
    .tap       (rx_word),
    .last      (rx_last)
  );

  serial_shift_unit #(.LEN(WORD_LEN), .OUT_W(1)) u_tx (
    .clk       (clk),
    .reset     (reset),
    .clr       (state_reg == ST_IDLE),
    .load      (tx_load),
    .load_data (tx_load_data),
    .shift_en  (tx_shift_en),
    .bit_in    (1'b0),
    .tap       (tx_tap),
    .last      (tx_last)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:   if (start) state_next = ST_HDR;
      ST_HDR:    if (hdr_last) state_next = is_write_reg ? ST_WDATA : ST_RFETCH;
      ST_WDATA:  if (rx_last) state_next = ST_WMEM;
      ST_WMEM:   state_next = more_words ? ST_WDATA : ST_DONE;
      ST_RFETCH: if (fetch_wait_reg) state_next = ST_RSHIFT;
      ST_RSHIFT: if (tx_last) state_next = more_words ? ST_RFETCH : ST_DONE;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    // Abort outranks every other transition, including end of burst
    if (state_reg != ST_IDLE && bus.rx_done_in) state_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= ST_IDLE;
      is_write_reg   <= 1'b0;
      fetch_wait_reg <= 1'b0;
      hdr_cnt_reg    <= '0;
      addr_reg       <= '0;
      burst_reg      <= '0;
      k_reg          <= '0;
    end else begin
      state_reg      <= state_next;
      fetch_wait_reg <= (state_reg == ST_RFETCH) && !fetch_wait_reg;
      if (start) is_write_reg <= bus.write_en;
      if (state_reg == ST_IDLE) begin
        hdr_cnt_reg <= '0;
        k_reg       <= '0;
      end else begin
        if (hdr_beat) hdr_cnt_reg <= hdr_cnt_reg + 1'b1;
        if (state_reg == ST_WMEM || tx_last) k_reg <= k_reg + 1'b1;
      end
      if (hdr_beat && hdr_cnt_reg < ADDR_BEATS)
        addr_reg <= {addr_reg[ADDR_W-2:0], bus.rx_address};
      if (hdr_beat && hdr_cnt_reg < BURST_BEATS)
        burst_reg <= {burst_reg[BURST_W-2:0], bus.rx_burst};
    end
  end

`ifdef SERIAL_SLAVE_PARITY_EN
  logic parity_err_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) parity_err_reg <= 1'b0;
    else if (state_reg == ST_WMEM && !parity_ok) parity_err_reg <= 1'b1;
  end

  assign bus.parity_err = parity_err_reg;
`else
  assign bus.parity_err = 1'b0;
`endif

  assign bus.slave_ready   = (state_reg == ST_IDLE) || (state_reg == ST_HDR) ||
                             (state_reg == ST_WDATA);
  assign bus.slave_valid   = (state_reg == ST_RSHIFT);
  assign bus.tx_data       = (state_reg == ST_RSHIFT) && tx_tap[0];
  assign bus.slave_tx_done = (state_reg == ST_DONE);

  // Address wraps naturally at ADDR_W bits
  assign mem_addr  = (state_reg == ST_WMEM || state_reg == ST_RFETCH) ?
                     addr_reg + ADDR_W'(k_reg) : '0;
  assign mem_wdata = (state_reg == ST_WMEM) ? rx_data_word : '0;
  assign mem_we    = (state_reg == ST_WMEM) && parity_ok;
  assign mem_re    = (state_reg == ST_RFETCH) && !fetch_wait_reg;

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: stimulus pushes expected writes, tx bits and
// done events; a negedge monitor pops and compares. Honours SERIAL_SLAVE_PARITY_EN.
module tb_serial_slave_port;
  import serial_bus_pkg::*;

  localparam int ADDR_W  = DEF_ADDR_W;
  localparam int BURST_W = DEF_BURST_W;
  localparam int DATA_W  = DEF_DATA_W;
  localparam int DEPTH   = 1 << ADDR_W;
  localparam int HB      = (ADDR_W > BURST_W) ? ADDR_W : BURST_W;
`ifdef SERIAL_SLAVE_PARITY_EN
  localparam int WL = DATA_W + 1;
`else
  localparam int WL = DATA_W;
`endif

  typedef struct { int addr; int data; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_slave_port_if bus();
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata = '0;

  serial_slave_port #(.ADDR_W(ADDR_W), .BURST_W(BURST_W), .DATA_W(DATA_W)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .bus       (bus),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata)
  );

  logic [DATA_W-1:0] phys_mem [0:DEPTH-1];
  logic [DATA_W-1:0] ref_mem  [0:DEPTH-1];
  logic [DATA_W-1:0] wbuf     [0:15];

  wr_t wq[$];
  bit  txq[$];
  int  dq[$];
  int  n_cmp = 0;
  int  n_bad = 0;
  int  cyc = 0;
  int  done_seen = 0;
  int  exp_perr = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) phys_mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= phys_mem[mem_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin : monitor
    wr_t e;
    int  ec;
    if (rst_n) begin
      if (mem_we) begin
        if (wq.size() == 0) chk("unexpected_write", 32'(mem_addr), 32'hFFFF_FFFF);
        else begin
          e = wq.pop_front();
          chk("write_addr", 32'(mem_addr), e.addr);
          chk("write_data", 32'(mem_wdata), e.data);
          $display("write  addr=%03h data=%02h", mem_addr, mem_wdata);
        end
      end
      if (bus.slave_valid) begin
        if (txq.size() == 0) chk("unexpected_tx_bit", 32'(bus.tx_data), 32'hFFFF_FFFF);
        else if (bus.master_ready) chk("tx_bit", 32'(bus.tx_data), 32'(txq.pop_front()));
        else chk("tx_hold", 32'(bus.tx_data), 32'(txq[0]));
      end
      if (bus.slave_tx_done) begin
        done_seen++;
        if (dq.size() == 0) chk("unexpected_done", 32'(cyc), 32'hFFFF_FFFF);
        else begin
          ec = dq.pop_front();
          if (ec >= 0) chk("done_cycle", 32'(cyc), 32'(ec));
          $display("done   cycle=%0d", cyc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_slave_ready"}, 32'(bus.slave_ready), 1);
    chk({tag, "_slave_valid"}, 32'(bus.slave_valid), 0);
    chk({tag, "_tx_data"}, 32'(bus.tx_data), 0);
    chk({tag, "_tx_done"}, 32'(bus.slave_tx_done), 0);
    chk({tag, "_parity_err"}, 32'(bus.parity_err), 0);
    chk({tag, "_mem_we"}, 32'(mem_we), 0);
    chk({tag, "_mem_re"}, 32'(mem_re), 0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 0);
    chk({tag, "_mem_wdata"}, 32'(mem_wdata), 0);
  endtask

  task automatic gaps(input int gm, input int idx);
    int g;
    g = (gm == 1) ? ((idx == 0) ? 0 : 2) : ((gm == 2) ? int'($urandom_range(0, 2)) : 0);
    bus.master_valid = 1'b0;
    repeat (g) tick();
  endtask

  task automatic start(input logic is_wr);
    bus.write_en = is_wr;
    bus.read_en  = ~is_wr;
    tick();
    bus.write_en = 1'b0;
    bus.read_en  = 1'b0;
  endtask

  task automatic header(input int addr, input int burst, input int gm);
    for (int b = 0; b < HB; b++) begin
      gaps(gm, b);
      bus.master_valid = 1'b1;
      bus.rx_address = (b < ADDR_W) ? addr[ADDR_W-1-b] : 1'($urandom);
      bus.rx_burst   = (b < BURST_W) ? burst[BURST_W-1-b] : 1'($urandom);
      tick();
    end
    bus.master_valid = 1'b0;
  endtask

  task automatic send_word(input logic [DATA_W-1:0] d, input logic bad, input int gm,
                           output int lastc);
    lastc = cyc;
    for (int b = 0; b < DATA_W; b++) begin
      gaps(gm, b);
      bus.master_valid = 1'b1;
      bus.rx_data = d[DATA_W-1-b];
      lastc = cyc;
      tick();
    end
`ifdef SERIAL_SLAVE_PARITY_EN
    gaps(gm, DATA_W);
    bus.master_valid = 1'b1;
    bus.rx_data = (^d) ^ bad;
    lastc = cyc;
    tick();
`else
    if (bad) $display("note: parity corruption ignored without parity beats");
`endif
    bus.master_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget, input string name);
    for (int i = 0; i < budget && done_seen < target; i++) tick();
    chk(name, 32'(done_seen >= target), 1);
  endtask

  task automatic do_write(input int addr, input int burst, input int gm, input int badmask);
    int  n, a, lastc, target;
    wr_t e;
    n = (burst == 0) ? 1 : burst;
    target = done_seen + 1;
    start(1'b1);
    header(addr, burst, gm);
    for (int k = 0; k < n; k++) begin
      a = (addr + k) % DEPTH;
      if (badmask[k]) exp_perr = 1;
      else begin
        e.addr = a;
        e.data = int'(wbuf[k]);
        wq.push_back(e);
        ref_mem[a] = wbuf[k];
      end
      send_word(wbuf[k], badmask[k], gm, lastc);
      if (k == n - 1) dq.push_back(lastc + 2);
      tick();
    end
    wait_done(target, 20, "write_done_seen");
  endtask

  task automatic do_read(input int addr, input int burst, input int gm, input int rmode);
    int n, target;
    logic [DATA_W-1:0] d;
    n = (burst == 0) ? 1 : burst;
    target = done_seen + 1;
    for (int k = 0; k < n; k++) begin
      d = ref_mem[(addr + k) % DEPTH];
      for (int b = 0; b < DATA_W; b++) txq.push_back(d[DATA_W-1-b]);
`ifdef SERIAL_SLAVE_PARITY_EN
      txq.push_back(^d);
`endif
      $display("read   addr=%03h expect=%02h", (addr + k) % DEPTH, d);
    end
    dq.push_back(-1);
    start(1'b0);
    header(addr, burst, gm);
    for (int i = 0; i < n * WL * 6 + 40 && done_seen < target; i++) begin
      bus.master_ready = (rmode == 0) ? 1'b1 : ((rmode == 1) ? (i % 2 == 1) : 1'($urandom));
      tick();
    end
    bus.master_ready = 1'b0;
    chk("read_done_seen", 32'(done_seen >= target), 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int  lc, op, a, bu, gm;
    wr_t e;
    for (int i = 0; i < DEPTH; i++) begin
      phys_mem[i] = DATA_W'($urandom);
      ref_mem[i]  = phys_mem[i];
    end
    bus.read_en = 0; bus.write_en = 0; bus.master_valid = 0; bus.master_ready = 0;
    bus.rx_done_in = 0; bus.rx_address = 0; bus.rx_burst = 0; bus.rx_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    rst_n = 1'b1;
    tick();

    // single word, continuous valid
    wbuf[0] = 8'hA5;
    do_write(12'h123, 1, 0, 0);

    // burst across the address wrap
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    do_write(12'hFFE, 3, 0, 0);

    // read burst with master_ready toggling
    phys_mem[12'h040] = 8'h3C; ref_mem[12'h040] = 8'h3C;
    phys_mem[12'h041] = 8'hC3; ref_mem[12'h041] = 8'hC3;
    do_read(12'h040, 2, 0, 1);

    // dual request plus junk beats must leave the port idle
    bus.read_en = 1; bus.write_en = 1;
    for (int i = 0; i < 4; i++) begin
      bus.master_valid = 1'b1;
      bus.rx_address = 1'($urandom); bus.rx_burst = 1'($urandom); bus.rx_data = 1'($urandom);
      tick();
    end
    bus.read_en = 0; bus.write_en = 0; bus.master_valid = 0;
    tick();
    wbuf[0] = 8'h5A;
    do_write(12'h2B7, 1, 1, 0);
    do_read(12'h2B7, 1, 1, 0);

    // abort during word 2 of a burst-4 write
    for (int k = 0; k < 4; k++) wbuf[k] = DATA_W'($urandom);
    e.addr = 12'h300; e.data = int'(wbuf[0]);
    wq.push_back(e);
    ref_mem[12'h300] = wbuf[0];
    start(1'b1);
    header(12'h300, 4, 0);
    send_word(wbuf[0], 1'b0, 0, lc);
    tick();
    for (int b = 0; b < 3; b++) begin
      bus.master_valid = 1'b1;
      bus.rx_data = wbuf[1][DATA_W-1-b];
      tick();
    end
    bus.master_valid = 1'b0;
    bus.rx_done_in = 1'b1;
    tick();
    bus.rx_done_in = 1'b0;
    wbuf[0] = 8'h96;
    do_write(12'h555, 1, 0, 0);
    chk("abort_no_write_301", 32'(phys_mem[12'h301]), 32'(ref_mem[12'h301]));

    // asynchronous reset in the middle of a read shift
    for (int k = 0; k < DATA_W; k++) txq.push_back(ref_mem[12'h555][DATA_W-1-k]);
`ifdef SERIAL_SLAVE_PARITY_EN
    txq.push_back(^ref_mem[12'h555]);
`endif
    start(1'b0);
    header(12'h555, 1, 0);
    for (int i = 0; i < 20 && !bus.slave_valid; i++) tick();
    chk("rshift_reached", 32'(bus.slave_valid), 1);
    bus.master_ready = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk_reset("mid_rshift_reset");
    txq.delete();
    dq.delete();
    exp_perr = 0;
    bus.master_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // randomized traffic
    for (int t = 0; t < 20; t++) begin
      op = $urandom_range(0, 1);
      a  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(DEPTH - 3, DEPTH - 1))
                                       : int'($urandom_range(0, DEPTH - 1));
      bu = $urandom_range(0, 3);
      gm = $urandom_range(0, 2);
      if (op == 1) begin
        for (int k = 0; k < 4; k++) wbuf[k] = DATA_W'($urandom);
        do_write(a, bu, gm, 0);
      end else begin
        do_read(a, bu, gm, $urandom_range(0, 2));
      end
    end

`ifdef SERIAL_SLAVE_PARITY_EN
    // wrong parity suppresses the write; the following word still lands
    wbuf[0] = 8'h0F; wbuf[1] = 8'h6E;
    do_write(12'h700, 2, 0, 1);
    chk("parity_err_set", 32'(bus.parity_err), 1);
    chk("parity_bad_not_written", 32'(phys_mem[12'h700]), 32'(ref_mem[12'h700]));
    wbuf[0] = 8'h81;
    do_write(12'h710, 1, 0, 0);
    chk("parity_err_sticky", 32'(bus.parity_err), 1);
`endif

    repeat (5) tick();
    chk("parity_err_final", 32'(bus.parity_err), 32'(exp_perr));
    chk("writes_outstanding", 32'(wq.size()), 0);
    chk("tx_bits_outstanding", 32'(txq.size()), 0);
    chk("done_outstanding", 32'(dq.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
